scan_gen: RTL

Raster scan generator upstream of metaball. Divides the system clock into a pixel strobe and walks the visible and blanking raster, driving metaball's px_stb, p_x, p_y and its per-frame mov_en. Also produces hsync, vsync and de for the display output. These are delayed by PIPE_LAT pixel strobes so they line up with the metaball vld/out stream.

---
 rtl/scan_gen.sv | 102 ++++++++++
 1 files changed

// File: rtl/scan_gen.sv
// scan_gen: pixel-strobe divider and raster walker feeding metaball, with
// sync/de outputs delayed PIPE_LAT strobes to line up with the metaball stream.
module scan_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PX_DIV   = 4,
   parameter int MOV_DIV  = 1,
   parameter int PIPE_LAT = 2,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   output logic       px_stb,
   output logic [9:0] p_x,
   output logic [9:0] p_y,
   output logic       active,
   output logic       mov_en,
   output logic       hsync,
   output logic       vsync,
   output logic       de
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW = PX_DIV > 1 ? $clog2(PX_DIV) : 1;
   localparam int FW = MOV_DIV > 1 ? $clog2(MOV_DIV) : 1;
   localparam logic [2:0] IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [9:0]    p_x_q, p_x_d, p_y_q, p_y_d;
   logic          px_stb_q, px_stb_d;
   logic          last_px, cand, hs_raw, vs_raw;
   logic [2:0]    raw;

   always_comb begin
      div_cnt_d   = (div_cnt_q == DW'(PX_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
      px_stb_d    = div_cnt_q == DW'(PX_DIV - 1);
      last_px     = p_x_q == 10'(H_TOTAL - 1);
      cand        = px_stb_q && last_px && p_y_q == 10'(V_ACTIVE - 1);
      p_x_d       = !px_stb_q ? p_x_q : last_px ? '0 : p_x_q + 10'd1;
      p_y_d       = !(px_stb_q && last_px) ? p_y_q :
                    (p_y_q == 10'(V_TOTAL - 1)) ? '0 : p_y_q + 10'd1;
      frame_cnt_d = !cand ? frame_cnt_q :
                    (frame_cnt_q == FW'(MOV_DIV - 1)) ? '0 : frame_cnt_q + 1'b1;
      hs_raw      = (p_x_q >= 10'(H_ACTIVE + H_FP) && p_x_q < 10'(H_ACTIVE + H_FP + H_SYNC))
                    ? SYNC_POL : ~SYNC_POL;
      vs_raw      = (p_y_q >= 10'(V_ACTIVE + V_FP) && p_y_q < 10'(V_ACTIVE + V_FP + V_SYNC))
                    ? SYNC_POL : ~SYNC_POL;
      raw         = {hs_raw, vs_raw, active};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt_q   <= '0;
         px_stb_q    <= 1'b0;
         p_x_q       <= '0;
         p_y_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         px_stb_q    <= px_stb_d;
         p_x_q       <= p_x_d;
         p_y_q       <= p_y_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign px_stb = px_stb_q;
   assign p_x    = p_x_q;
   assign p_y    = p_y_q;
   assign active = p_x_q < 10'(H_ACTIVE) && p_y_q < 10'(V_ACTIVE);
   assign mov_en = cand && frame_cnt_q == FW'(MOV_DIV - 1);

   generate
      if (PIPE_LAT == 0) begin : g_nodl
         assign {hsync, vsync, de} = raw;
      end else begin : g_dl
         logic [2:0] dl_q [PIPE_LAT];
         logic [2:0] dl_d [PIPE_LAT];
         always_comb begin
            dl_d[0] = px_stb_q ? raw : dl_q[0];
            for (int i = 1; i < PIPE_LAT; i++)
               dl_d[i] = px_stb_q ? dl_q[i-1] : dl_q[i];
         end
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int i = 0; i < PIPE_LAT; i++)
                  dl_q[i] <= IDLE;
            end else begin
               dl_q <= dl_d;
            end
         end
         assign {hsync, vsync, de} = dl_q[PIPE_LAT-1];
      end
   endgenerate
endmodule
